// File: rtl/axis_master.sv
// rtl/axis_master.sv - AXI4-Stream master: MLP result words through a small FIFO onto a packetised stream
module axis_master #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int C_FIFO_DEPTH         = 4,
    parameter int C_PACKET_LEN         = 10
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESET,
    input  logic                                pi_mlp_data_valid,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     pi_mlp_data,
    output logic                                po_data_read,
    output logic                                po_fifo_full,
    output logic                                po_packet_done,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (C_PACKET_LEN > 1) ? $clog2(C_PACKET_LEN) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(C_FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(C_PACKET_LEN - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t                          state_q, state_d;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];
    logic [PW-1:0]                   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                   count_q, count_d;
    logic [BW-1:0]                   beat_q, beat_d;
    logic                            full_q, full_d;
    logic                            done_q, done_d;
    logic                            push, pop, last_beat;

    // A full FIFO refuses the producer even if a beat leaves on the same edge.
    assign push         = pi_mlp_data_valid && !full_q;
    assign po_data_read = push;
    assign pop          = M_AXIS_TVALID && M_AXIS_TREADY;
    assign last_beat    = (beat_q == LAST_BEAT);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            beat_d   = last_beat ? '0 : beat_q + BW'(1);
        end
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        full_d = (count_d == FULL_CNT);
        done_d = pop && last_beat;
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            full_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            full_q   <= full_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESET && push) mem_q[wr_ptr_q] <= pi_mlp_data;
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = (count_d != '0) ? S_STREAM : S_IDLE;
    end

    always_comb begin
        M_AXIS_TVALID  = (state_q == S_STREAM);
        M_AXIS_TDATA   = mem_q[rd_ptr_q];
        M_AXIS_TSTRB   = '1;
        M_AXIS_TLAST   = M_AXIS_TVALID && last_beat;
        po_fifo_full   = full_q;
        po_packet_done = done_q;
    end
endmodule

// File: tb/tb_axis_master.sv
// tb/tb_axis_master.sv - queue-model bench for axis_master (packet length 10 and 1)
module tb_axis_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        vld [2];
    logic [31:0] dat [2];
    logic        trdy [2];
    logic        rd [2], full [2], pd [2], tv [2], tl [2];
    logic [31:0] td [2];
    logic [3:0]  ts [2];

    axis_master #(.C_M_AXIS_TDATA_WIDTH(32), .C_FIFO_DEPTH(4), .C_PACKET_LEN(10)) dut0 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
        .pi_mlp_data_valid(vld[0]), .pi_mlp_data(dat[0]),
        .po_data_read(rd[0]), .po_fifo_full(full[0]), .po_packet_done(pd[0]),
        .M_AXIS_TVALID(tv[0]), .M_AXIS_TDATA(td[0]), .M_AXIS_TSTRB(ts[0]),
        .M_AXIS_TLAST(tl[0]), .M_AXIS_TREADY(trdy[0]));

    axis_master #(.C_M_AXIS_TDATA_WIDTH(32), .C_FIFO_DEPTH(4), .C_PACKET_LEN(1)) dut1 (
        .M_AXIS_ACLK(clk), .M_AXIS_ARESET(rst),
        .pi_mlp_data_valid(vld[1]), .pi_mlp_data(dat[1]),
        .po_data_read(rd[1]), .po_fifo_full(full[1]), .po_packet_done(pd[1]),
        .M_AXIS_TVALID(tv[1]), .M_AXIS_TDATA(td[1]), .M_AXIS_TSTRB(ts[1]),
        .M_AXIS_TLAST(tl[1]), .M_AXIS_TREADY(trdy[1]));

    int checks = 0;
    int errors = 0;

    logic [31:0] mq0 [$], mq1 [$];
    logic [31:0] src0 [$], src1 [$];
    logic [31:0] out0 [$], out1 [$];
    logic [31:0] tlq0 [$], tlq1 [$];
    int  beats [2];
    bit  pdx [2];
    bit  took [2];
    int  acc [2];
    int  pdc [2];
    bit  model_on = 0;
    bit  rnd_on = 0;
    int  cyc = 0;
    int  ft_acc, ft_tv, first_hs, last_hs;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int msize(int i);
        return (i == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic logic [31:0] mfront(int i);
        if (msize(i) == 0) return 32'h0;
        return (i == 0) ? mq0[0] : mq1[0];
    endfunction

    // Reference: FIFO is a queue, a beat is last when (beats sent) mod len == len-1.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin : per_dut
            int sz, len;
            logic [31:0] fr;
            bit etv, efull, etl, erd;
            sz    = msize(i);
            fr    = mfront(i);
            len   = (i == 0) ? 10 : 1;
            etv   = (sz > 0);
            efull = (sz == 4);
            etl   = etv && ((beats[i] % len) == len - 1);
            erd   = vld[i] && !efull;
            if (model_on) begin
                chk($sformatf("dut%0d tvalid", i), tv[i], etv);
                chk($sformatf("dut%0d full", i), full[i], efull);
                chk($sformatf("dut%0d tlast", i), tl[i], etl);
                chk($sformatf("dut%0d data_read", i), rd[i], erd);
                chk($sformatf("dut%0d packet_done", i), pd[i], pdx[i]);
                chk($sformatf("dut%0d tstrb", i), ts[i], 4'hF);
                if (etv) chk($sformatf("dut%0d tdata", i), td[i], fr);
            end
            took[i] = rd[i] && vld[i] && !rst;
            if (pd[i]) pdc[i]++;
            if (tv[i] && trdy[i] && !rst) begin
                if (i == 0) begin
                    out0.push_back(td[0]);
                    if (tl[0]) tlq0.push_back(td[0]);
                    if (first_hs < 0) first_hs = cyc;
                    last_hs = cyc;
                end else begin
                    out1.push_back(td[1]);
                    if (tl[1]) tlq1.push_back(td[1]);
                end
            end
            if (i == 0 && took[0] && ft_acc < 0) ft_acc = cyc;
            if (i == 0 && tv[0] && ft_tv < 0) ft_tv = cyc;
            if (rst) begin
                if (i == 0) mq0.delete(); else mq1.delete();
                beats[i] = 0;
                pdx[i]   = 0;
                model_on = 1;
            end else begin
                pdx[i] = etv && trdy[i] && etl;
                if (etv && trdy[i]) begin
                    if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                    beats[i]++;
                end
                if (erd) begin
                    if (i == 0) mq0.push_back(dat[0]); else mq1.push_back(dat[1]);
                end
            end
        end
    end

    // Producer: hold the word until it is taken, then present the next one.
    initial begin
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0;
            dat[i] = 32'h0;
        end
        forever begin
            @(posedge clk); #1;
            if (took[0] && src0.size() > 0) begin void'(src0.pop_front()); acc[0]++; end
            if (took[1] && src1.size() > 0) begin void'(src1.pop_front()); acc[1]++; end
            vld[0] = (src0.size() > 0);
            dat[0] = vld[0] ? src0[0] : 32'h0;
            vld[1] = (src1.size() > 0);
            dat[1] = vld[1] ? src1[0] : 32'h0;
            if (rnd_on) trdy[1] = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic clear_rec();
        out0.delete(); out1.delete(); tlq0.delete(); tlq1.delete();
        for (int i = 0; i < 2; i++) begin acc[i] = 0; pdc[i] = 0; end
        ft_acc = -1; ft_tv = -1; first_hs = -1; last_hs = -1;
    endtask

    task automatic wait_drain(int i, int budget);
        int n = 0;
        while (n < budget && ((i == 0) ? (src0.size() > 0 || vld[0] || tv[0])
                                       : (src1.size() > 0 || vld[1] || tv[1]))) begin
            tick(1);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: still busy after %0d cycles", i, budget);
        end
        tick(2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src0.delete();
        src1.delete();
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        trdy[0] = 1'b0;
        trdy[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin beats[i] = 0; pdx[i] = 0; took[i] = 0; end
        clear_rec();
        tick(3);
        rst = 1'b0;
        chk("reset tvalid", tv[0], 1'b0);
        chk("reset tlast", tl[0], 1'b0);
        chk("reset full", full[0], 1'b0);
        chk("reset packet_done", pd[0], 1'b0);

        // Back-to-back stream of 20 words
        clear_rec();
        trdy[0] = 1'b1;
        for (int k = 0; k < 20; k++) src0.push_back(k);
        wait_drain(0, 100);
        chk("stream beats", out0.size(), 20);
        chk("stream tlast count", tlq0.size(), 2);
        chk("stream tlast first", (tlq0.size() > 0) ? tlq0[0] : 32'hDEAD, 9);
        chk("stream tlast second", (tlq0.size() > 1) ? tlq0[1] : 32'hDEAD, 19);
        chk("stream packet_done pulses", pdc[0], 2);
        chk("stream latency", ft_tv - ft_acc, 1);
        chk("stream one per cycle", last_hs - first_hs, 19);

        // Backpressure, then full + pop
        clear_rec();
        trdy[0] = 1'b0;
        for (int k = 0; k < 6; k++) src0.push_back(100 + k);
        tick(8);
        chk("bp accepted", acc[0], 4);
        chk("bp full", full[0], 1'b1);
        chk("bp data_read", rd[0], 1'b0);
        chk("bp tdata", td[0], 100);
        trdy[0] = 1'b1;
        @(negedge clk);
        chk("full pop no accept", rd[0], 1'b0);
        @(negedge clk);
        chk("accept resumes", rd[0], 1'b1);
        tick(1);
        wait_drain(0, 100);
        chk("bp beats", out0.size(), 6);
        for (int k = 0; k < 6; k++)
            chk("bp order", (k < out0.size()) ? out0[k] : 32'hDEAD, 100 + k);

        // Gapped packet: 3 words, idle, 7 words
        do_reset();
        clear_rec();
        trdy[0] = 1'b1;
        for (int k = 0; k < 3; k++) src0.push_back(200 + k);
        wait_drain(0, 50);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("gap tvalid", tv[0], 1'b0);
        end
        for (int k = 3; k < 10; k++) src0.push_back(200 + k);
        wait_drain(0, 50);
        chk("gap tlast count", tlq0.size(), 1);
        chk("gap tlast word", (tlq0.size() > 0) ? tlq0[0] : 32'hDEAD, 209);

        // Reset after 4 beats with 2 words buffered
        do_reset();
        clear_rec();
        trdy[0] = 1'b1;
        for (int k = 0; k < 4; k++) src0.push_back(300 + k);
        wait_drain(0, 50);
        trdy[0] = 1'b0;
        src0.push_back(304);
        src0.push_back(305);
        tick(4);
        chk("pre-reset tvalid", tv[0], 1'b1);
        chk("pre-reset tdata", td[0], 304);
        rst = 1'b1;
        src0.delete();
        tick(1);
        chk("tvalid after reset", tv[0], 1'b0);
        tick(1);
        rst = 1'b0;
        clear_rec();
        trdy[0] = 1'b1;
        for (int k = 0; k < 10; k++) src0.push_back(400 + k);
        wait_drain(0, 60);
        chk("post-reset beats", out0.size(), 10);
        for (int k = 0; k < 10; k++)
            chk("post-reset order", (k < out0.size()) ? out0[k] : 32'hDEAD, 400 + k);
        chk("post-reset tlast count", tlq0.size(), 1);
        chk("post-reset tlast word", (tlq0.size() > 0) ? tlq0[0] : 32'hDEAD, 409);

        // Packet length 1 with random ready
        clear_rec();
        rnd_on = 1;
        for (int k = 0; k < 100; k++) src1.push_back(500 + k);
        wait_drain(1, 2000);
        rnd_on = 0;
        trdy[1] = 1'b0;
        chk("rand beats", out1.size(), 100);
        chk("rand tlast count", tlq1.size(), 100);
        chk("rand packet_done pulses", pdc[1], 100);
        for (int k = 0; k < 100; k++)
            chk("rand order", (k < out1.size()) ? out1[k] : 32'hDEAD, 500 + k);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/axis_master.md
# axis_master

Transmit end of the MLP AXI4-Stream path. Accepts result words from the MLP core through a valid/read handshake, buffers them in a small FIFO, and drives them onto an AXI4-Stream master port toward the DMA. TLAST is asserted on every C_PACKET_LEN-th beat. This is the outbound counterpart of the inbound stream slave that feeds the MLP core.

## Interface
- C_M_AXIS_TDATA_WIDTH, 32: stream data width in bits. Must be a multiple of 8.
- C_FIFO_DEPTH, 4: FIFO entries. Power of 2, at least 2.
- C_PACKET_LEN, 10: beats per packet. At least 1.
- M_AXIS_ACLK  in  1  single clock for the whole block.
- M_AXIS_ARESET  in  1  reset; synchronous, active-high.
- pi_mlp_data_valid  in  1  MLP result word available on pi_mlp_data.
- pi_mlp_data  in  C_M_AXIS_TDATA_WIDTH  MLP result word.
- po_data_read  out  1  combinational; word accepted this cycle.
- po_fifo_full  out  1  registered; FIFO holds C_FIFO_DEPTH words.
- po_packet_done  out  1  registered; one-cycle pulse after the TLAST beat completes.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  beat data.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte qualifier; constant all ones.
- M_AXIS_TLAST  out  1  last beat of packet.
- M_AXIS_TREADY  in  1  downstream ready.

## Operation
**Input side**
- po_data_read = pi_mlp_data_valid && !po_fifo_full.
- When po_data_read is high, pi_mlp_data is written at wr_ptr on the same rising edge, and wr_ptr increments modulo C_FIFO_DEPTH.
- The producer holds valid and data until it sees po_data_read. After that cycle it either drops valid or presents the next word.

**FIFO**
- Occupancy counter runs 0..C_FIFO_DEPTH. Pointers wrap modulo C_FIFO_DEPTH.
- Push and pop in the same cycle leave occupancy unchanged.
- When full, no push is accepted even if a pop happens in the same cycle. po_data_read stays low for that cycle.
- po_fifo_full = (occupancy == C_FIFO_DEPTH), registered.

**Output side**
- State IDLE: occupancy 0, M_AXIS_TVALID = 0.
- State STREAM: occupancy > 0, M_AXIS_TVALID = 1, M_AXIS_TDATA = fifo[rd_ptr].
- A handshake is M_AXIS_TVALID && M_AXIS_TREADY. On a handshake, rd_ptr increments and beat_cnt increments.
- beat_cnt wraps to 0 after reaching C_PACKET_LEN-1.
- M_AXIS_TLAST = M_AXIS_TVALID && (beat_cnt == C_PACKET_LEN-1). With C_PACKET_LEN = 1, every beat is last.
- beat_cnt persists across IDLE gaps. A packet may span stalls and empty periods.
- po_packet_done pulses high for exactly one cycle, in the cycle after the TLAST handshake.

**Reset**
- On reset, all of the following clear: pointers, occupancy, beat_cnt, state = IDLE, po_packet_done = 0.
- Reset outputs: M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, po_fifo_full = 0. po_data_read follows pi_mlp_data_valid combinationally but no write occurs while reset is high.
- Reset mid-packet discards buffered words and any partial packet. The next accepted word is beat 0.

## Timing
- Latency: a word accepted at edge k is presented with M_AXIS_TVALID high in the cycle after edge k.
- Throughput: 1 word/cycle sustained when M_AXIS_TREADY is held high.
- AXI stability: while M_AXIS_TVALID && !M_AXIS_TREADY, M_AXIS_TDATA and M_AXIS_TLAST hold constant.
- M_AXIS_TVALID never deasserts without a handshake.
- M_AXIS_TVALID does not depend combinationally on M_AXIS_TREADY.
- Simultaneous push and pop with occupancy 0 is impossible. The pushed word becomes visible next cycle.

## Test plan
- Streaming: C_PACKET_LEN = 10, TREADY held 1, feed words 0..19 back-to-back.
  - Required: 20 beats, one per cycle, first beat 1 cycle after first accept.
  - Required: TLAST on data 9 and data 19; po_packet_done pulses twice.
- Backpressure: TREADY held 0, feed 6 words.
  - Required: 4 accepted, then po_fifo_full = 1 and po_data_read = 0.
  - Required: TDATA = word 0, stable while stalled.
  - Then raise TREADY: words 0..5 out in order with no loss.
- Full + pop: FIFO full, TREADY = 1, producer valid.
  - Required: no accept in the cycle full is seen; accept resumes on the next cycle.
  - Required: pointers wrap correctly, output order preserved.
- Gapped packet: 3 words, 5 idle cycles, 7 words.
  - Required: TVALID low during the gap; TLAST only on the 10th word overall.
- Reset mid-packet: reset after 4 of 10 beats, with 2 words buffered.
  - Required: TVALID = 0 the cycle after reset; buffered words dropped.
  - Required: the next 10 words form a full packet, TLAST on the 10th.
- Random TREADY: C_PACKET_LEN = 1, random TREADY, 100 words.
  - Required: every beat has TLAST = 1, data matches scoreboard, TSTRB = 4'hF always.
